fetch_exec_ctrl: RTL
====================

FETCH_EXEC_CTRL -- requirements
Module: fetch_exec_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port E  in  1  memory phase flag: 0 = fetch, 1 = execute.
REQ-006 SHALL have port PC_in  in  32  address of the instruction currently in Iout.
REQ-007 SHALL have port Iout  in  32  instruction being executed.
REQ-008 SHALL have port Mout  in  32  load data; valid in the fetch cycle after an execute.
REQ-009 SHALL have port Next_PC  out  32  next fetch address presented to memory.
REQ-010 SHALL have port data_addr_out  out  32  load/store byte address.
REQ-011 SHALL have port data_out  out  32  store data.
REQ-012 SHALL have port S  out  1  store strobe, sampled by memory while E=1.
REQ-013 SHALL have port instr_cnt  out  CNT_W  retired-instruction count.
REQ-014 SHALL have port phase_err  out  1  sticky phase-mismatch flag.
REQ-015 SHALL have port halted  out  1  halt indication.

Function
REQ-016 SHALL implement states FETCH (expects E=0) and EXEC (expects E=1); FETCH->EXEC and EXEC->FETCH every cycle.
REQ-017 SHALL decode Iout as opcode[31:26], rs[25:21], rt[20:16], imm[15:0]: 6'b100011 = LW, 6'b101011 = SW, any other opcode = NOP.
REQ-018 SHALL, in EXEC, drive data_addr_out = R[rs] + sign-extended imm (mod 2^32), data_out = R[rt], S = 1 only for SW; combinational from Iout.
REQ-019 SHALL drive S = 0, data_addr_out = 0, data_out = 0 outside EXEC, during phase error, and while halted.
REQ-020 SHALL, at the end of a valid EXEC, advance pc by 4 (wrapping 32'hFFFF_FFFC -> 0), increment instr_cnt (wrapping), and for LW record rt as the pending load.
REQ-021 SHALL, in FETCH with a pending load, write Mout into R[rt] and clear the pending load; load latency = 1 cycle, and the next EXEC reads the new value.
REQ-022 SHALL hold R0 at zero; writes to R0 are discarded.
REQ-023 SHALL drive Next_PC = pc (registered), stable for the whole cycle.
REQ-024 SHALL, on E mismatching the state, set phase_err (sticky until Reset), suppress the store, pc advance, counter increment and write-back for that cycle, and resynchronise so that next state = (E ? FETCH : EXEC).

Reset
REQ-025 SHALL, with Reset high at a clock edge, set pc = Next_PC = RESET_PC, state = FETCH, instr_cnt = 0, phase_err = 0, halted = 0, all registers = 0, and no pending load.
REQ-026 SHALL let Reset take priority over all other events, discarding any pending load mid-operation.

Configuration
REQ-027 SHALL, with FETCH_EXEC_HALT_EN defined, treat opcode 6'b111111 in EXEC as HALT: set halted = 1, freeze pc, instr_cnt and registers, and force S = 0 until Reset.
REQ-028 SHALL, without FETCH_EXEC_HALT_EN, treat opcode 6'b111111 as NOP and tie halted to 0.

Structure
REQ-029 SHALL place opcode constants, the state enum and the instruction field positions in shared package fetch_exec_pkg.
REQ-030 SHALL implement the 32x32 register file (2 read ports, 1 write port, R0 = 0) as sub-module fetch_exec_regfile.

Verification
REQ-031 SHALL check reset: Reset high for 2 cycles -> Next_PC = 0, S = 0, instr_cnt = 0, phase_err = 0, halted = 0.
REQ-032 SHALL check NOP stream: Iout = 32'h8000_0000 for 3 EXEC phases -> Next_PC = 32'h0000_000C, instr_cnt = 3, S never 1.
REQ-033 SHALL check load then store: LW 32'h8C04_0040 -> data_addr_out = 32'h40, S = 0; Mout = 32'h100 in the next FETCH; SW 32'hAC85_0022 -> data_addr_out = 32'h122, S = 1, data_out = 0.
REQ-034 SHALL check R0 load: LW 32'h8C00_0040 with Mout = 32'hDEAD_BEEF, then SW 32'hAC00_0000 -> data_out = 0.
REQ-035 SHALL check phase error: E = 1 during FETCH -> phase_err = 1 (sticky), S = 0, Next_PC unchanged that cycle, then normal alternation resumes.
REQ-036 SHALL check halt: Iout = 32'hFC00_0000 -> with macro, halted = 1 and Next_PC frozen; without macro, Next_PC advances by 4.

Source files
------------

// File: rtl/fetch_exec_pkg.sv
// ---------------------------------------------------------------------------
// fetch_exec_pkg
// Shared definitions for the fetch/execute controller slice:
//   - state_t     : two-phase controller state (FETCH / EXEC)
//   - OP_*        : recognised opcodes (LW, SW, HALT)
//   - field positions of the 32-bit instruction word
//   - sext_imm()  : sign-extends the 16-bit immediate to 32 bits
// ---------------------------------------------------------------------------
package fetch_exec_pkg;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   function automatic logic signed [31:0] sext_imm(input logic [15:0] imm);
      return signed'({{16{imm[15]}}, imm});
   endfunction

endpackage

// File: rtl/fetch_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_exec_ctrl_if
// Memory-side bus of the fetch/execute controller.
//   E             : memory phase flag (0 = fetch, 1 = execute), from memory
//   PC_in         : address of the instruction currently on Iout
//   Iout          : instruction being executed
//   Mout          : load data, valid in the fetch cycle after an execute
//   Next_PC       : next fetch address, to memory
//   data_addr_out : load/store byte address, to memory
//   data_out      : store data, to memory
//   S             : store strobe, sampled by memory while E = 1
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_exec_ctrl_if;
   logic        E;
   logic [31:0] PC_in;
   logic [31:0] Iout;
   logic [31:0] Mout;
   logic [31:0] Next_PC;
   logic [31:0] data_addr_out;
   logic [31:0] data_out;
   logic        S;

   modport master (
      input  E, PC_in, Iout, Mout,
      output Next_PC, data_addr_out, data_out, S
   );

   modport slave (
      output E, PC_in, Iout, Mout,
      input  Next_PC, data_addr_out, data_out, S
   );
endinterface

// File: rtl/fetch_exec_regfile.sv
// ---------------------------------------------------------------------------
// fetch_exec_regfile
// 32 x 32-bit register file, two asynchronous read ports, one synchronous
// write port. R0 always reads zero and writes to it are dropped.
// Ports:
//   clk, Reset   : clock, synchronous active-high reset (clears all regs)
//   ra1/rd1      : read port 1 address / data
//   ra2/rd2      : read port 2 address / data
//   we, wa, wd   : write enable, address, data
// ---------------------------------------------------------------------------
module fetch_exec_regfile (
   input  logic        clk,
   input  logic        Reset,
   input  logic [4:0]  ra1,
   output logic [31:0] rd1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] regs [32];

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/fetch_exec_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_exec_ctrl
// Two-phase (FETCH/EXEC) controller executing LW/SW over a shared memory.
// In EXEC the load/store address and store data are produced
// combinationally from Iout; a load's data arrives on Mout in the following
// FETCH and is written back then. A phase mismatch between E and the
// internal state raises a sticky phase_err, suppresses all side effects
// for that cycle and resynchronises the state to memory.
// Parameters:
//   RESET_PC : pc value after reset
//   CNT_W    : width of the retired-instruction counter
// Ports:
//   clk, Reset : clock, synchronous active-high reset
//   bus        : fetch_exec_ctrl_if.master (E, PC_in, Iout, Mout in;
//                Next_PC, data_addr_out, data_out, S out)
//   instr_cnt  : retired-instruction count (wraps)
//   phase_err  : sticky phase-mismatch flag
//   halted     : halt indication
// Configuration macro: FETCH_EXEC_HALT_EN -- opcode 6'b111111 halts the
// controller until Reset; otherwise it is a NOP and halted is tied low.
// ---------------------------------------------------------------------------
module fetch_exec_ctrl
   import fetch_exec_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic                clk,
   input  logic                Reset,
   fetch_exec_ctrl_if.master   bus,
   output logic [CNT_W-1:0]    instr_cnt,
   output logic                phase_err,
   output logic                halted
);

   state_t      state;
   logic [31:0] pc;
   logic        pend_vld;
   logic [4:0]  pend_rt;

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [15:0] imm;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic signed [31:0] imm_sx;

   logic phase_ok;
   logic exec_ok;
   logic fetch_ok;
   logic is_lw;
   logic is_sw;
   logic is_halt;
   logic wb_en;

   // PC_in is informational only; the controller keeps its own pc.
   logic unused_pc_in;
   assign unused_pc_in = ^bus.PC_in;

   assign opcode = bus.Iout[OP_MSB:OP_LSB];
   assign rs     = bus.Iout[RS_MSB:RS_LSB];
   assign rt     = bus.Iout[RT_MSB:RT_LSB];
   assign imm    = bus.Iout[IMM_MSB:IMM_LSB];
   assign imm_sx = sext_imm(imm);

   assign is_lw = (opcode == OP_LW);
   assign is_sw = (opcode == OP_SW);

   // Memory phase must agree with the state; only then may anything commit.
   assign phase_ok = ((state == ST_EXEC) == bus.E);
   assign exec_ok  = phase_ok && (state == ST_EXEC)  && !halted;
   assign fetch_ok = phase_ok && (state == ST_FETCH) && !halted;
   assign wb_en    = fetch_ok && pend_vld;

   fetch_exec_regfile u_regfile (
      .clk   (clk),
      .Reset (Reset),
      .ra1   (rs),
      .rd1   (rs_data),
      .ra2   (rt),
      .rd2   (rt_data),
      .we    (wb_en),
      .wa    (pend_rt),
      .wd    (bus.Mout)
   );

   always_comb begin
      bus.S             = 1'b0;
      bus.data_addr_out = 32'd0;
      bus.data_out      = 32'd0;
      if (exec_ok) begin
         bus.S             = is_sw;
         bus.data_addr_out = rs_data + $unsigned(imm_sx);
         bus.data_out      = rt_data;
      end
   end

   assign bus.Next_PC = pc;

`ifdef FETCH_EXEC_HALT_EN
   logic halted_q;

   assign is_halt = (opcode == OP_HALT);
   assign halted  = halted_q;

   always_ff @(posedge clk) begin
      if (Reset)
         halted_q <= 1'b0;
      else if (exec_ok && is_halt)
         halted_q <= 1'b1;
   end
`else
   assign is_halt = 1'b0;
   assign halted  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= ST_FETCH;
         pc        <= RESET_PC;
         instr_cnt <= '0;
         phase_err <= 1'b0;
         pend_vld  <= 1'b0;
         pend_rt   <= 5'd0;
      end else if (!phase_ok) begin
         // Follow memory: E=1 means it is executing, so we fetch next.
         phase_err <= 1'b1;
         state     <= bus.E ? ST_FETCH : ST_EXEC;
      end else begin
         state <= (state == ST_FETCH) ? ST_EXEC : ST_FETCH;
         if (exec_ok && !is_halt) begin
            pc        <= pc + 32'd4;
            instr_cnt <= instr_cnt + CNT_W'(1);
            if (is_lw) begin
               pend_vld <= 1'b1;
               pend_rt  <= rt;
            end
         end
         if (fetch_ok) pend_vld <= 1'b0;
      end
   end

endmodule
